// File: rtl/axi_hp0_rd.sv
// AXI3 read master for the Zynq HP0 port: streams fixed-length INCR bursts out of a
// DDR ring region into a show-ahead FIFO and presents them on a valid/ready stream.
module axi_hp0_rd #(
   parameter logic [31:0] STAR_ADDR     = 32'h0100_0000,
   parameter logic [31:0] REGION_SIZE   = 32'h0040_0000,
   parameter int          AXI_BURST_LEN = 16,
   parameter int          FIFO_DEPTH    = 32
) (
   input  logic        AXI_clk,
   input  logic        rst,
   input  logic        i_enable,
   output logic [63:0] o_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [31:0] o_burst_cnt,
   output logic        o_resp_err,
   output logic        o_len_err,
   output logic [31:0] AXI_araddr,
   output logic [3:0]  AXI_arlen,
   output logic [2:0]  AXI_arsize,
   output logic [1:0]  AXI_arburst,
   output logic [1:0]  AXI_arlock,
   output logic [3:0]  AXI_arcache,
   output logic [2:0]  AXI_arprot,
   output logic [3:0]  AXI_arqos,
   output logic [5:0]  AXI_arid,
   output logic        AXI_arvalid,
   input  logic        AXI_arready,
   input  logic [63:0] AXI_rdata,
   input  logic [5:0]  AXI_rid,
   input  logic [1:0]  AXI_rresp,
   input  logic        AXI_rlast,
   input  logic        AXI_rvalid,
   output logic        AXI_rready
);

   localparam int          PW          = $clog2(FIFO_DEPTH);
   localparam int          CW          = PW + 1;
   localparam int          BW          = $clog2(AXI_BURST_LEN + 1);
   localparam logic [31:0] BURST_BYTES = 32'(AXI_BURST_LEN * 8);
   localparam logic [31:0] END_ADDR    = STAR_ADDR + REGION_SIZE;
   localparam logic [CW-1:0] LEN_C     = CW'(AXI_BURST_LEN);
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] LEN_B     = BW'(AXI_BURST_LEN);

   typedef enum logic [1:0] {IDLE, RADDR, RDATA, DONE} state_t;

   typedef struct packed {
      logic        vld;
      logic [63:0] data;
   } beat_t;

   state_t        state, state_nxt;
   logic [BW-1:0] beat_cnt;
   logic [CW-1:0] count;
   logic [CW-1:0] free;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [63:0]   mem [FIFO_DEPTH];
   beat_t         push;
   logic          pop;
   logic          rd_hs;
   logic          beat_in_range;
   logic [31:0]   addr_inc, addr_nxt;
   logic          unused_rid;

   assign AXI_arlen   = 4'(AXI_BURST_LEN - 1);
   assign AXI_arsize  = 3'b011;
   assign AXI_arburst = 2'b01;
   assign AXI_arlock  = 2'b00;
   assign AXI_arcache = 4'b0010;
   assign AXI_arprot  = 3'h0;
   assign AXI_arqos   = 4'h0;
   assign AXI_arid    = 6'h0;
   assign unused_rid  = ^AXI_rid;

   assign rd_hs         = AXI_rvalid & AXI_rready;
   assign beat_in_range = beat_cnt < LEN_B;
   assign pop           = o_valid & i_ready;
   assign free          = DEPTH_C - count;
   assign o_valid       = count != '0;
   assign o_data        = mem[rd_ptr];

   // Beats past the burst length are dropped so the reserved FIFO space is never exceeded.
   always_comb begin
      push      = '0;
      push.vld  = rd_hs & beat_in_range;
      push.data = AXI_rdata;
   end

   always_comb begin
      addr_inc = AXI_araddr + BURST_BYTES;
      addr_nxt = (addr_inc >= END_ADDR) ? STAR_ADDR : addr_inc;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_enable && free >= LEN_C) state_nxt = RADDR;
         RADDR:   if (AXI_arvalid && AXI_arready) state_nxt = RDATA;
         RDATA:   if (rd_hs && AXI_rlast) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge AXI_clk) begin
      if (rst) begin
         state       <= IDLE;
         AXI_araddr  <= STAR_ADDR;
         AXI_arvalid <= 1'b0;
         AXI_rready  <= 1'b0;
         o_burst_cnt <= '0;
         o_resp_err  <= 1'b0;
         o_len_err   <= 1'b0;
         beat_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         AXI_rready <= (state_nxt == RDATA);
         // arvalid rises one cycle after entering RADDR and drops on the handshake edge
         if (state == RADDR)
            AXI_arvalid <= !(AXI_arvalid && AXI_arready);
         if (rd_hs) begin
            if (AXI_rresp != 2'b00) o_resp_err <= 1'b1;
            if (beat_in_range) beat_cnt <= beat_cnt + 1'b1;
            else               o_len_err <= 1'b1;
            if (AXI_rlast && (!beat_in_range || beat_cnt != LEN_B - 1'b1))
               o_len_err <= 1'b1;
         end
         if (state == DONE) begin
            o_burst_cnt <= o_burst_cnt + 32'd1;
            beat_cnt    <= '0;
            AXI_araddr  <= addr_nxt;
         end
      end
   end

   always_ff @(posedge AXI_clk) begin
      if (rst) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push.vld) wr_ptr <= wr_ptr + 1'b1;
         if (pop)      rd_ptr <= rd_ptr + 1'b1;
         case ({push.vld, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge AXI_clk) begin
      if (push.vld) mem[wr_ptr] <= push.data;
   end

endmodule

// File: doc/axi_hp0_rd.md
Name: axi_hp0_rd

Overview:
- AXI3 read master for the Zynq HP0 port.
- Streams 64-bit words back out of the DDR ring region that the HP0 write path fills.
- Issues fixed-length INCR bursts starting at STAR_ADDR, wraps at the end of the region, and buffers read data in an internal synchronous FIFO.
- Presents the buffered data to the downstream consumer on a valid/ready stream.
- Single clock domain (AXI_clk).

Parameters:
STAR_ADDR, 32'h0100_0000, first byte address of the ring region (128-byte aligned)
REGION_SIZE, 32'h0040_0000, ring size in bytes (multiple of 128)
AXI_BURST_LEN, 16, beats per burst (1..16; AXI3 limit)
FIFO_DEPTH, 32, internal read-data FIFO entries (power of 2, >= 2*AXI_BURST_LEN)

Ports:
AXI_clk  input  1  clock for all logic
rst  input  1  synchronous active-high reset
i_enable  input  1  level; 1 = keep issuing bursts, 0 = stop after the current burst
o_data  output  64  stream data, FIFO head (show-ahead)
o_valid  output  1  o_data valid (FIFO not empty)
i_ready  input  1  consumer accepts o_data when o_valid&i_ready
o_burst_cnt  output  32  completed read bursts, wraps at 2^32
o_resp_err  output  1  sticky: some beat had RRESP != OKAY
o_len_err  output  1  sticky: RLAST beat number != AXI_BURST_LEN, or extra beats arrived
AXI_araddr  output  32  burst start address
AXI_arlen  output  4  constant AXI_BURST_LEN-1
AXI_arsize  output  3  constant 3'b011 (8 bytes)
AXI_arburst  output  2  constant 2'b01 (INCR)
AXI_arlock  output  2  constant 2'b00
AXI_arcache  output  4  constant 4'b0010
AXI_arprot  output  3  constant 3'h0
AXI_arqos  output  4  constant 4'h0
AXI_arid  output  6  constant 6'h0
AXI_arvalid  output  1  address valid
AXI_arready  input  1  address accepted
AXI_rdata  input  64  read data
AXI_rid  input  6  ignored
AXI_rresp  input  2  read response
AXI_rlast  input  1  last beat
AXI_rvalid  input  1  read data valid
AXI_rready  output  1  read data accept

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; AXI_araddr=STAR_ADDR; AXI_arvalid=0; AXI_rready=0.
  - FIFO emptied, so o_valid=0 and o_data is don't-care.
  - o_burst_cnt=0; o_resp_err=0; o_len_err=0; beat counter=0.
  - Reset mid-burst abandons the burst with no drain. The HP0 interconnect must be reset together with this block.
- One burst outstanding at most.
- A burst is issued only when FIFO free entries >= AXI_BURST_LEN. FIFO space is therefore reserved and never overflows from AXI.
- FSM:
  - IDLE: if i_enable and free >= AXI_BURST_LEN -> RADDR; otherwise stay.
  - RADDR: AXI_arvalid=1, registered and asserted the cycle after entry. It is held with AXI_araddr stable until AXI_arvalid&AXI_arready; -> RDATA on that edge, arvalid=0 the next cycle.
  - RDATA: AXI_rready=1, registered, high for the whole state. Each AXI_rvalid&AXI_rready beat increments the beat counter (0..AXI_BURST_LEN).
    - Beats 1..AXI_BURST_LEN are pushed into the FIFO.
    - Beats beyond AXI_BURST_LEN are dropped and set o_len_err.
    - On a beat with AXI_rlast: if beat number != AXI_BURST_LEN, set o_len_err. Then -> DONE.
    - Any beat with AXI_rresp != 2'b00 sets o_resp_err; the data is still pushed.
  - DONE (1 cycle): rready=0; o_burst_cnt+1; beat counter cleared; AXI_araddr advanced (see below). -> IDLE.
- Address arithmetic (32-bit):
  - next = AXI_araddr + AXI_BURST_LEN*8.
  - If next >= STAR_ADDR+REGION_SIZE, next = STAR_ADDR.
  - The last burst read starts at STAR_ADDR+REGION_SIZE-AXI_BURST_LEN*8.
- i_enable dropping during RADDR/RDATA does not abort: the burst completes, then the FSM waits in IDLE.
- FIFO:
  - Synchronous, show-ahead.
  - Push and pop in the same cycle are both honoured, count unchanged.
  - Pop = o_valid & i_ready.
  - Push-to-o_valid latency: 1 cycle when empty.
  - o_data is held stable while o_valid & !i_ready.
- Minimum burst-to-burst gap: DONE + IDLE + RADDR entry = 3 cycles after the RLAST edge before the next arvalid.

Test Plan:
- Reset, i_enable=1, slave arready=1 immediately, rvalid every cycle with rlast on beat 16, i_ready=1 -> first araddr=32'h0100_0000, second 32'h0100_0080; 16 words per burst on o_data in order; o_burst_cnt=2 after two bursts; error flags 0.
- i_ready=0 throughout -> exactly 2 bursts issued (FIFO 32 full). No third arvalid until at least 16 words are popped; then one more burst issued.
- REGION_SIZE=32'h100, run 3 bursts -> araddr 0x0100_0000, 0x0100_0080, 0x0100_0000.
- Slave returns rresp=2'b10 on beat 5 and rlast on beat 12 -> o_resp_err=1, o_len_err=1, both sticky. 12 words in FIFO; FSM back to IDLE; o_burst_cnt increments.
- Slave delays arready 7 cycles and inserts rvalid gaps -> araddr/arvalid held stable throughout; no FIFO push on rvalid=0 cycles; data order preserved.
- rst=1 asserted in RDATA after beat 8 -> next cycle arvalid=0, rready=0, o_valid=0, o_burst_cnt=0, araddr=STAR_ADDR.
